// File: rtl/dtc_if.sv
// Code handshake between a producer and the digital-to-time converter.
//   code_in    : W-bit code to convert (master -> slave)
//   code_valid : code_in is valid      (master -> slave)
//   code_ready : slave can accept now  (slave -> master)
// A code is accepted on a rising clk edge where code_valid & code_ready.
interface dtc_if #(
  parameter int W = 5
);
  logic [W-1:0] code_in;
  logic         code_valid;
  logic         code_ready;

  modport master (output code_in, output code_valid, input  code_ready);
  modport slave  (input  code_in, input  code_valid, output code_ready);
endinterface

// File: rtl/dtc_edge_gen.sv
// Digital-to-time converter. Accepts a W-bit code over the bus handshake and
// emits two rising edges: ref_out at conversion start, then del_out
// (T_WAIT + code) clk periods later. Both fall together one cycle after
// del_out rises, a one-cycle done pulse marks the fall, and both stay low for
// at least T_RECOVER cycles before the next conversion.
//
// Ports:
//   clk      : clock
//   rst      : asynchronous, active-low reset (aborts any conversion, no done)
//   bus      : dtc_if.slave (code_in, code_valid, code_ready)
//   ref_out  : reference edge, registered
//   del_out  : delayed edge, registered
//   busy     : high from accept until return to IDLE
//   done     : one-cycle pulse as both edges fall
//
// Optional feature macro: DTC_BACK2BACK_EN
//   When defined, a new code may also be accepted in RECOVER once its counter
//   reaches zero, giving back-to-back conversions with exactly T_RECOVER low
//   cycles between them. Undefined (default): accept only in IDLE.
module dtc_edge_gen #(
  parameter int W         = 5,
  parameter int T_WAIT    = 3,  // >= 1
  parameter int T_RECOVER = 2   // >= 1
) (
  input  logic clk,
  input  logic rst,
  dtc_if.slave bus,
  output logic ref_out,
  output logic del_out,
  output logic busy,
  output logic done
);

  // Wide enough for the largest delay T_WAIT + 2^W - 1.
  localparam int CW = $clog2(T_WAIT + 2**W);
  localparam logic [CW-1:0] RECOVER_LOAD = CW'(T_RECOVER - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          ref_q,   ref_d;
  logic          del_q,   del_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic          accept;
  logic [CW-1:0] dly;

  // Total delay in cycles; zero-extended so it never overflows CW bits.
  assign dly = CW'(T_WAIT) + CW'(bus.code_in);

`ifdef DTC_BACK2BACK_EN
  assign bus.code_ready = rst & ((state_q == ST_IDLE) ||
                                 (state_q == ST_RECOVER && cnt_q == '0));
`else
  assign bus.code_ready = rst & (state_q == ST_IDLE);
`endif

  assign accept = bus.code_valid & bus.code_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    del_d   = del_q;
    busy_d  = busy_q;
    done_d  = 1'b0;  // done is only ever a one-cycle pulse out of HOLD

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ref_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = dly - CW'(1);  // counting down to 0 lands del_out on E0+D
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          del_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        // Both edges fall together so pulse widths differ by exactly D.
        ref_d   = 1'b0;
        del_d   = 1'b0;
        done_d  = 1'b1;
        cnt_d   = RECOVER_LOAD;
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
`ifdef DTC_BACK2BACK_EN
          if (accept) begin
            ref_d   = 1'b1;
            cnt_d   = dly - CW'(1);
            state_d = ST_RUN;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ref_q   <= 1'b0;
      del_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      del_q   <= del_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from flops: glitch-free edges.
  assign ref_out = ref_q;
  assign del_out = del_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dtc_edge_gen.sv
// Directed self-checking bench for dtc_edge_gen with default parameters
// (W=5, T_WAIT=3, T_RECOVER=2). Outputs are sampled 1 ns after each rising
// edge; sample k is the state just after edge E0+k, E0 being the accept edge.
module tb_dtc_edge_gen;

  localparam int W         = 5;
  localparam int T_WAIT    = 3;
  localparam int T_RECOVER = 2;
  localparam int MAX_S     = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ref_out, del_out, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic ref_a  [MAX_S];
  logic del_a  [MAX_S];
  logic done_a [MAX_S];
  logic busy_a [MAX_S];
  logic rdy_a  [MAX_S];

  dtc_if #(.W(W)) bus ();

  dtc_edge_gen #(
    .W(W), .T_WAIT(T_WAIT), .T_RECOVER(T_RECOVER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ref_out (ref_out),
    .del_out (del_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int k);
    ref_a[k]  = ref_out;
    del_a[k]  = del_out;
    done_a[k] = done;
    busy_a[k] = busy;
    rdy_a[k]  = bus.code_ready;
  endtask

  // Bounded wait for code_ready; an expired bound counts as a failure.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.code_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Presents a code until it is accepted; returns just after edge E0 with
  // code_valid dropped and code_in replaced by code_after.
  task automatic accept(input string tag, input logic [W-1:0] code,
                        input logic [W-1:0] code_after);
    bus.code_valid = 1'b0;
    wait_ready(tag);
    bus.code_in    = code;
    bus.code_valid = 1'b1;
    tick();
    bus.code_valid = 1'b0;
    bus.code_in    = code_after;
  endtask

  // One full conversion with D = T_WAIT + code, checking edge timing.
  task automatic run_conv(input string tag, input int code, input int code_after);
    int d;
    d = T_WAIT + code;
    accept(tag, W'(code), W'(code_after));
    for (int k = 0; k <= d + 3; k++) begin
      record(k);
      if (k < d + 3) tick();
    end
    check({tag, "_ref_rise_E0"},   ref_a[0],      1);
    check({tag, "_busy_E0"},       busy_a[0],     1);
    check({tag, "_del_low_E0"},    del_a[0],      0);
    check({tag, "_del_low_pre"},   del_a[d-1],    0);
    check({tag, "_del_rise"},      del_a[d],      1);
    check({tag, "_ref_high_del"},  ref_a[d],      1);
    check({tag, "_done_low_del"},  done_a[d],     0);
    check({tag, "_ref_fall"},      ref_a[d+1],    0);
    check({tag, "_del_fall"},      del_a[d+1],    0);
    check({tag, "_done_pulse"},    done_a[d+1],   1);
    check({tag, "_done_clear"},    done_a[d+2],   0);
    check({tag, "_busy_recover"},  busy_a[d+2],   1);
    check({tag, "_busy_idle"},     busy_a[d+3],   0);
    check({tag, "_ready_idle"},    rdy_a[d+3],    1);
`ifdef DTC_BACK2BACK_EN
    check({tag, "_ready_recover"}, rdy_a[d+2],    1);
`else
    check({tag, "_ready_recover"}, rdy_a[d+2],    0);
`endif
    check({tag, "_ready_run"},     rdy_a[1],      0);
  endtask

  initial begin
    int rise_k;
    bus.code_in    = '0;
    bus.code_valid = 1'b0;

    // 1. Reset held with activity on the inputs.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.code_valid = i[0];
      bus.code_in    = W'(i * 7);
      tick();
      check("rst_ref",   ref_out,        0);
      check("rst_del",   del_out,        0);
      check("rst_done",  done,           0);
      check("rst_busy",  busy,           0);
      check("rst_ready", bus.code_ready, 0);
    end
    bus.code_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rel_ready", bus.code_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rel_ref",  ref_out, 0);
      check("rel_del",  del_out, 0);
      check("rel_busy", busy,    0);
    end

    // 2. code=0 : del at E0+3, fall at E0+4, ready again after E0+6.
    run_conv("c0", 0, 0);
    // 3. code=31 : del at E0+34, fall at E0+35, busy drops at E0+37.
    run_conv("c31", 31, 31);
    // 4. code=7, code_in changed to 0 after accept : del still at E0+10.
    run_conv("c7chg", 7, 0);
    check("c7chg_del_at_10", del_a[10], 1);
    check("c7chg_del_not_3", del_a[3],  0);

    // 5. code=20 aborted by reset mid-RUN.
    accept("abort", W'(20), W'(20));
    for (int i = 0; i < 4; i++) tick();
    check("abort_pre_ref", ref_out, 1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_ref",   ref_out,        0);
    check("abort_del",   del_out,        0);
    check("abort_busy",  busy,           0);
    check("abort_ready", bus.code_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", done,    0);
      check("abort_ref_low", ref_out, 0);
    end
    rst = 1'b1;
    tick();
    run_conv("c1post", 1, 1);

    // 6. code_valid held high with code=0 : second ref rise at E0+6 with
    // back-to-back enabled, E0+7 without.
    bus.code_valid = 1'b0;
    wait_ready("b2b");
    bus.code_in    = '0;
    bus.code_valid = 1'b1;
    tick();
    record(0);
    rise_k = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      record(k);
      if (rise_k < 0 && k >= 2 && ref_a[k-1] == 1'b0 && ref_a[k] == 1'b1) rise_k = k;
    end
    bus.code_valid = 1'b0;
    check("b2b_first_ref", ref_a[0], 1);
    check("b2b_fall",      ref_a[4], 0);
`ifdef DTC_BACK2BACK_EN
    check("b2b_second_rise", rise_k, 6);
    check("b2b_busy_gap",    busy_a[5], 1);
`else
    check("b2b_second_rise", rise_k, 7);
    check("b2b_busy_gap",    busy_a[6], 0);
`endif
    wait_ready("b2b_end");
    for (int i = 0; i < 8; i++) tick();
    check("end_busy", busy,    0);
    check("end_ref",  ref_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
